note_player: RTL
================

// Module: note_player
// PURPOSE
//  Playback counterpart of the note recorder. Stores a melody of 3-bit notes, each with a hold
//  duration, then replays it as a timed note stream (note_out/note_valid) for a tone generator or
//  a recorder under test. Controlled by the same 2-bit op encoding style as the recorder.
//  Single clock domain; one register stage between the control inputs and the outputs.
// PARAMETERS
//  DEPTH  128  melody capacity in entries (power of two)
//  AW     7    log2(DEPTH); width of pos
//  DUR_W  4    width of the per-note duration field
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      synchronous, active-high
//  wr_en       in   1      append {note_in, dur_in} to the melody
//  note_in     in   3      note code to store (0 = rest, still emitted with note_valid=1)
//  dur_in      in   DUR_W  hold time; the note is held for dur_in+1 cycles
//  op          in   2      00 nop, 01 play/resume, 10 pause, 11 clear
//  note_out    out  3      note being played; 0 when not playing
//  note_valid  out  1      high while in PLAY
//  pos         out  AW     index of the entry currently played
//  len         out  AW+1   number of stored entries (0..DEPTH)
//  busy        out  1      high in PLAY or PAUSE
//  done        out  1      one-cycle pulse after the last note finishes
// BEHAVIOUR
//  - Reset: state=IDLE, note_out=0, note_valid=0, pos=0, len=0, busy=0, done=0, timer=0.
//    Memory contents need no reset.
//  - FSM states: IDLE, PLAY, PAUSE. All outputs are registered.
//  - Write
//    - Accepted only in IDLE, with len<DEPTH and op!=11.
//    - An accepted write stores the entry at index len; len increments on that edge.
//    - Ignored when full, in PLAY, or in PAUSE. Ignored writes have no side effects.
//  - IDLE, op=01
//    - If len>0: on the sampling edge go to PLAY, set pos=0, note_out=mem[0].note,
//      note_valid=1, timer=mem[0].dur. Outputs are visible right after that edge.
//    - If len==0: ignored; stay in IDLE.
//  - PLAY, per cycle with op=00 or 01
//    - timer!=0: decrement timer.
//    - timer==0 and pos<len-1: pos+1, load the next note and its duration.
//    - timer==0 and pos==len-1: go to IDLE; note_out=0, note_valid=0, pos=0; done=1 for one cycle.
//  - PLAY, op=10: go to PAUSE. Timer and pos freeze; note_valid=0, note_out=0.
//  - PAUSE, op=01: go to PLAY. note_out=mem[pos].note, note_valid=1, timer resumes from its
//    frozen value, so remaining hold time is preserved. op=10 or op=00 in PAUSE: hold.
//  - op=11 (any state): go to IDLE; len=0, pos=0, note_out=0, note_valid=0, done=0.
//    Clear beats a simultaneous wr_en. Clear on the same edge a melody ends suppresses done.
//  - op=10 in IDLE: no effect.
//  - Synchronous reset mid-play overrides everything and returns all reset values on the next edge.
//  - Total play time = sum over entries of (dur_i + 1) cycles; the done pulse comes one cycle
//    after the last note_valid cycle.
// CONFIGURATION
//  - NOTE_PLAYER_LOOP_EN defined: at the end of the last note the FSM wraps to pos=0 and loads
//    mem[0] with no gap; note_valid stays high. done pulses once per completed pass; the FSM never
//    self-exits PLAY (use op=10 or op=11).
//  - NOTE_PLAYER_LOOP_EN undefined: single pass, as described above.
// TESTING
//  - Reset, then write {1,d0},{2,d1},{3,d0}; op=01 -> len=3. note_out is 1 for 1 cycle,
//    2 for 2 cycles, 3 for 1 cycle, then done=1 for one cycle and note_out=0.
//  - Write 128 entries, then a 129th -> len=128, 129th ignored. Play: pos walks 0..127, then done.
//  - Play {5,d3}; op=10 after 2 cycles for 4 cycles, then op=01 -> note 5 held 2 more cycles,
//    note_valid=0 during the pause.
//  - op=01 with len=0 -> stays IDLE, busy=0. wr_en during PLAY -> len unchanged.
//  - wr_en with op=11 on the same edge -> len=0. op=11 mid-play -> note_valid=0 next cycle,
//    no done pulse.
//  - With NOTE_PLAYER_LOOP_EN, melody {1,d0},{2,d0} -> note_out 1,2,1,2,... with done high
//    on every pass boundary.

Source files
------------

// File: rtl/note_player_if.sv
// note_player_if: control and note-stream bundle between a controller and note_player
interface note_player_if #(parameter int AW = 7, parameter int DUR_W = 4);
  logic wr_en;
  logic [2:0] note_in;
  logic [DUR_W-1:0] dur_in;
  logic [1:0] op;
  logic [2:0] note_out;
  logic note_valid;
  logic [AW-1:0] pos;
  logic [AW:0] len;
  logic busy;
  logic done;
  modport master (output wr_en, note_in, dur_in, op, input note_out, note_valid, pos, len, busy, done);
  modport slave (input wr_en, note_in, dur_in, op, output note_out, note_valid, pos, len, busy, done);
endinterface

// File: rtl/note_player.sv
// note_player: melody store and timed note replay; NOTE_PLAYER_LOOP_EN wraps playback endlessly
module note_player #(parameter int DEPTH = 128, parameter int AW = 7, parameter int DUR_W = 4) (
  input logic clk,
  input logic reset,
  note_player_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2;
`ifdef NOTE_PLAYER_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  logic [1:0] st_q, st_d;
  logic [AW-1:0] pos_q, pos_d, nxt;
  logic [AW:0] len_q, len_d;
  logic [DUR_W-1:0] tmr_q, tmr_d;
  logic [2:0] note_q, note_d;
  logic done_q, done_d, wr_ok, last;
  logic [2:0] mem_note [DEPTH];
  logic [DUR_W-1:0] mem_dur [DEPTH];
  always_comb begin
    wr_ok = bus.wr_en && st_q == IDLE && !len_q[AW] && bus.op != 2'b11;
    last = {1'b0, pos_q} == len_q - (AW+1)'(1);
    nxt = last ? '0 : pos_q + AW'(1);
    st_d = st_q;
    pos_d = pos_q;
    len_d = len_q + (AW+1)'(wr_ok);
    tmr_d = tmr_q;
    note_d = note_q;
    done_d = 1'b0;
    if (bus.op == 2'b11) begin
      st_d = IDLE;
      len_d = '0;
      pos_d = '0;
      note_d = '0;
    end else begin
      case (st_q)
        IDLE: if (bus.op == 2'b01 && len_q != '0) begin
          st_d = PLAY;
          pos_d = '0;
          note_d = mem_note[0];
          tmr_d = mem_dur[0];
        end
        PLAY: if (bus.op == 2'b10) begin
          st_d = PAUSE;
          note_d = '0;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - DUR_W'(1);
        end else if (!last || LOOP) begin
          pos_d = nxt;
          note_d = mem_note[nxt];
          tmr_d = mem_dur[nxt];
          done_d = last;
        end else begin
          st_d = IDLE;
          pos_d = '0;
          note_d = '0;
          done_d = 1'b1;
        end
        PAUSE: if (bus.op == 2'b01) begin
          st_d = PLAY;
          note_d = mem_note[pos_q];
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      pos_q <= '0;
      len_q <= '0;
      tmr_q <= '0;
      note_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pos_q <= pos_d;
      len_q <= len_d;
      tmr_q <= tmr_d;
      note_q <= note_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_note[len_q[AW-1:0]] <= bus.note_in;
      mem_dur[len_q[AW-1:0]] <= bus.dur_in;
    end
  end
  assign bus.note_out = note_q;
  assign bus.note_valid = st_q == PLAY;
  assign bus.busy = st_q != IDLE;
  assign bus.pos = pos_q;
  assign bus.len = len_q;
  assign bus.done = done_q;
endmodule
